// File: rtl/synth_param_bank.sv
// synth_param_bank: a bank of user-adjustable synth settings.
// Each setting is stepped up or down by increment/decrement buttons that act
// on the currently selected slot. Features:
//   - press edge detection;
//   - hold-to-auto-repeat;
//   - saturating arithmetic;
//   - a wrap-around selector;
//   - direct load;
//   - a per-slot display nibble.
module synth_param_bank #(
  parameter int                            NUM_PARAMS   = 6,
  parameter int                            WIDTH        = 32,
  parameter int                            STEP_SHIFT   = 24,
  parameter logic [NUM_PARAMS*WIDTH-1:0]   DEFAULT_VEC  = '0,
  parameter int                            REPEAT_DELAY = 25_000_000,
  parameter int                            REPEAT_RATE  = 5_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inc,
  input  logic                          dec,
  input  logic                          sel_next,
  input  logic                          sel_prev,
  input  logic                          load_en,
  input  logic [3:0]                    load_idx,
  input  logic [WIDTH-1:0]              load_val,
  output logic [3:0]                    sel,
  output logic [NUM_PARAMS*WIDTH-1:0]   params,
  output logic [WIDTH-1:0]              sel_value,
  output logic [3:0]                    sel_nibble,
  output logic                          update,
  output logic                          at_max,
  output logic                          at_min
);

  // One counter serves both the initial hold delay and the repeat interval,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [WIDTH:0]   STEP       = {{WIDTH{1'b0}}, 1'b1} << STEP_SHIFT;
  localparam logic [3:0]       LAST_SEL   = 4'(NUM_PARAMS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  logic             inc_q, dec_q, next_q, prev_q;
  logic             inc_press, dec_press, next_press, prev_press;
  logic [3:0]       sel_nxt;
  logic             sel_change;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_up, dir_nxt;
  logic             held;
  logic             step_en, step_up;
  logic [WIDTH:0]   ext, sum, diff;
  logic [WIDTH-1:0] step_val;
  logic             load_hit;
  logic             changed;
  logic [WIDTH-1:0] slots    [NUM_PARAMS];
  logic [WIDTH-1:0] slot_nxt [NUM_PARAMS];

  // A press is the first cycle a button is seen high after being low.
  assign inc_press  = inc & ~inc_q;
  assign dec_press  = dec & ~dec_q;
  assign next_press = sel_next & ~next_q;
  assign prev_press = sel_prev & ~prev_q;

  // The button that started the current hold. It must stay down for the hold
  // to continue.
  assign held = dir_up ? inc : dec;

  // Out-of-range load indices are dropped entirely.
  assign load_hit = load_en && ({28'd0, load_idx} < 32'(NUM_PARAMS));

  // Register each button level once, for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      inc_q  <= inc;
      dec_q  <= dec;
      next_q <= sel_next;
      prev_q <= sel_prev;
    end
  end

  // Wrap-around selector. Opposing presses in the same cycle cancel out.
  always_comb begin
    sel_nxt = sel;
    if (next_press && !prev_press) begin
      sel_nxt = (sel == LAST_SEL) ? 4'd0 : sel + 4'd1;
    end else if (prev_press && !next_press) begin
      sel_nxt = (sel == 4'd0) ? LAST_SEL : sel - 4'd1;
    end
  end

  assign sel_change = (sel_nxt != sel);

  // Repeat FSM: decides when a step fires. Holding both buttons, or moving the
  // selection mid-hold, parks the machine in LOCK until everything is released.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_up;
    step_en   = 1'b0;
    step_up   = dir_up;
    if (inc && dec) begin
      state_nxt = S_LOCK;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inc_press) begin
            step_en   = 1'b1;
            step_up   = 1'b1;
            dir_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_DELAY;
          end else if (dec_press) begin
            step_en   = 1'b1;
            step_up   = 1'b0;
            dir_nxt   = 1'b0;
            cnt_nxt   = '0;
            state_nxt = S_DELAY;
          end
        end
        S_DELAY: begin
          if (sel_change) begin
            state_nxt = S_LOCK;
            cnt_nxt   = '0;
          end else if (!held) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (REPEAT_DELAY != 0) begin
            if (cnt == DELAY_LAST) begin
              step_en   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_REPEAT;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        S_REPEAT: begin
          if (sel_change) begin
            state_nxt = S_LOCK;
            cnt_nxt   = '0;
          end else if (!held) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == RATE_LAST) begin
            step_en = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_LOCK: begin
          if (!inc && !dec) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Selector, FSM state and the shared counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel    <= 4'd0;
      state  <= S_IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
    end else begin
      sel    <= sel_nxt;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_up <= dir_nxt;
    end
  end

  // Read out the selected slot. A mux loop keeps the index in range for any
  // NUM_PARAMS.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (sel == 4'(i)) begin
        sel_value = slots[i];
      end
    end
  end

  assign sel_nibble = sel_value[WIDTH-1 -: 4];
  assign at_max     = &sel_value;
  assign at_min     = ~|sel_value;

  // Saturating step. One extra bit catches the carry or the borrow.
  always_comb begin
    ext  = {1'b0, sel_value};
    sum  = ext + STEP;
    diff = ext - STEP;
    if (step_up) begin
      step_val = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end else begin
      step_val = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
    end
  end

  // Next slot values. A load beats a step to the same slot. Any real change
  // raises the update flag.
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      slot_nxt[i] = slots[i];
      if (load_hit && load_idx == 4'(i)) begin
        slot_nxt[i] = load_val;
      end else if (step_en && sel == 4'(i)) begin
        slot_nxt[i] = step_val;
      end
      if (slot_nxt[i] != slots[i]) begin
        changed = 1'b1;
      end
    end
  end

  // Slot storage and the one-cycle update pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        slots[i] <= DEFAULT_VEC[i*WIDTH +: WIDTH];
      end
      update <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        slots[i] <= slot_nxt[i];
      end
      update <= changed;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PARAMS; g++) begin : g_pack
      assign params[g*WIDTH +: WIDTH] = slots[g];
    end
  endgenerate

endmodule

// File: doc/synth_param_bank.md
# synth_param_bank

Parametrised bank of user-adjustable synth settings such as octave, amplitude, attack, decay, sustain and release. Each setting is held in a register and changed by increment/decrement buttons that act on the currently selected slot. It adds what the single-purpose slider registers lacked:
- press edge detection and hold-to-auto-repeat;
- saturating arithmetic;
- a wrap-around slot selector;
- direct load;
- a per-slot display nibble.

It sits between the PS/2 key decoder and the ALU controller / HEX display logic.

## Interface
Parameters:
- NUM_PARAMS, 6, number of slots (2..16)
- WIDTH, 32, bits per slot
- STEP_SHIFT, 24, step size = 1 << STEP_SHIFT (must be < WIDTH)
- DEFAULT_VEC, 0, NUM_PARAMS*WIDTH packed reset values; slot i = bits [i*WIDTH +: WIDTH]
- REPEAT_DELAY, 25_000_000, hold cycles before auto-repeat starts; 0 disables auto-repeat
- REPEAT_RATE, 5_000_000, cycles between repeated steps (>= 1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inc  in  1  increment button level (already synchronised)
- dec  in  1  decrement button level
- sel_next  in  1  select-next button level
- sel_prev  in  1  select-previous button level
- load_en  in  1  direct write strobe
- load_idx  in  4  slot index for the direct write
- load_val  in  WIDTH  value for the direct write
- sel  out  4  currently selected slot
- params  out  NUM_PARAMS*WIDTH  all slot values, packed as DEFAULT_VEC
- sel_value  out  WIDTH  value of the selected slot
- sel_nibble  out  4  sel_value[WIDTH-1 -: 4], for the hex decoder
- update  out  1  one-cycle pulse when any slot value changes
- at_max / at_min  out  1 each  selected slot == 2^WIDTH-1 / == 0

## Operation
- Edge detection: inc, dec, sel_next and sel_prev are each registered once. A press is the cycle where the input is 1 and its registered copy is 0.
- Selector:
  - A sel_next press increments sel; NUM_PARAMS-1 wraps to 0.
  - A sel_prev press decrements sel; 0 wraps to NUM_PARAMS-1.
  - Both pressed in the same cycle: sel is unchanged.
- Step:
  - An increment adds STEP and saturates at 2^WIDTH-1.
  - A decrement subtracts STEP and saturates at 0.
  - All arithmetic is WIDTH+1 bits wide and then clamped. No wrap-around ever occurs.
- Repeat FSM (states IDLE, DELAY, REPEAT, LOCK; one shared counter of clog2 width):
  - IDLE: an inc-only or dec-only press performs one step and goes to DELAY with counter = 0.
  - DELAY: the counter counts while the same single button stays held. When the counter reaches REPEAT_DELAY-1, it steps, resets the counter and goes to REPEAT. If REPEAT_DELAY = 0, DELAY holds with no further steps.
  - REPEAT: steps every REPEAT_RATE cycles while the button is held.
  - Any state: if inc and dec are both 1, go to LOCK with no step.
  - DELAY/REPEAT: release of the held button returns to IDLE.
  - LOCK: leaves only when inc and dec are both 0, then goes to IDLE. Releasing only one button does not start a step.
  - A selection change while in DELAY or REPEAT goes to LOCK, so a held button never carries over to the new slot.
- Direct load:
  - load_en with load_idx < NUM_PARAMS writes load_val into that slot.
  - It has priority over a step to the same slot in the same cycle; that step is discarded.
  - A step to a different slot still applies.
  - load_idx >= NUM_PARAMS: the write is ignored and update stays 0.
- update pulses only if a stored value actually differs. A step at saturation, or a load of an identical value, gives update = 0.

## Timing
- Reset, synchronous and taking priority over everything, sets:
  - each slot = DEFAULT_VEC slice; sel = 0; FSM = IDLE; counter = 0;
  - edge registers = 0; update = 0.
- Reset asserted mid-hold aborts the hold. If the button is still held after reset deasserts, the edge register (cleared to 0) makes the next high cycle count as a fresh press.
- A press sampled at edge N produces the new value on params/sel_value and update = 1 after edge N+1 (1-cycle latency). Load latency is the same.
- sel_value, sel_nibble, at_max and at_min are combinational from sel and the slot registers. They are valid in the same cycle sel changes.
- Auto-repeat steps fall on press+REPEAT_DELAY, then every REPEAT_RATE cycles after that.

## Test plan
- Reset with NUM_PARAMS=6, WIDTH=8, STEP_SHIFT=4, DEFAULT_VEC={8'hF0,8'h00,8'h80,8'h10,8'hFF,8'h04}: slot0=04, slot5=F0, sel=0, update=0.
- Select slot 1 (FF), press inc for 1 cycle -> value stays FF, update=0, at_max=1. Then press dec -> EF, update pulses once, 1 cycle after the press.
- REPEAT_DELAY=10, REPEAT_RATE=4; hold inc on slot0 (04) for 30 cycles -> steps at cycles 0, 10, 14, 18, 22, 26; final value 0x64.
- sel_prev from sel=0 -> sel=5. Then hold inc, press sel_next mid-hold -> sel=0, no step on slot0 until inc is released and re-pressed.
- inc and dec pressed together -> no change, FSM in LOCK. Release dec only -> still no step; release both, then press inc -> one step.
- load_en idx=2 val=0x33 in the same cycle as an inc press on sel=2 -> slot2=0x33, update=1. load_idx=7 -> no change, update=0.
